// File: rtl/cm_ram_mch_if.sv
// Multi-channel RAM access bus: per-channel request/write/address/data lanes,
// with shared read data and one-hot grant/valid flags returned to requesters.
interface cm_ram_mch_if #(
  parameter int CH    = 4,
  parameter int ASIZE = 10,
  parameter int DSIZE = 18
);
  logic [CH-1:0]       req;
  logic [CH-1:0]       wr;
  logic [CH*ASIZE-1:0] addr;
  logic [CH*DSIZE-1:0] wdata;
  logic [CH-1:0]       gnt;
  logic [DSIZE-1:0]    rdata;
  logic [CH-1:0]       rvalid;

  modport master (output req, wr, addr, wdata, input  gnt, rdata, rvalid);
  modport slave  (input  req, wr, addr, wdata, output gnt, rdata, rvalid);
endinterface

// File: rtl/cm_ram_mch.sv
// Single-port RAM shared by CH requesters through a round-robin arbiter,
// with a zero-fill sequence after reset or on a clr pulse.
module cm_ram_mch #(
  parameter int DSIZE  = 18,
  parameter int ASIZE  = 10,
  parameter int CH     = 4,
  parameter int RD_LAT = 2
) (
  input  logic           clock,
  input  logic           rst_n,
  input  logic           clr,
  output logic           init_done,
  cm_ram_mch_if.slave    bus
);
  localparam int PW = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_q, state_d;
  logic [ASIZE-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CH-1:0]     gnt;
  logic              gnt_any;
  logic [PW-1:0]     gidx;
  logic [ASIZE-1:0]  gaddr;
  logic [DSIZE-1:0]  gwdata;
  logic              gwr;
  logic              grd;
  int unsigned       idx;

  logic [DSIZE-1:0]  mem [2**ASIZE];
  logic [CH-1:0]     vpipe [RD_LAT];
  logic [DSIZE-1:0]  dpipe [RD_LAT];

  // Round-robin search starting at ptr; grants only while RUN.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gidx    = '0;
    idx     = 0;
    if (state_q == RUN) begin
      for (int unsigned off = 0; off < CH; off++) begin
        idx = (32'(ptr_q) + off) % CH;
        if (!gnt_any && bus.req[idx]) begin
          gnt_any = 1'b1;
          gidx    = PW'(idx);
        end
      end
    end
    if (gnt_any) gnt[gidx] = 1'b1;
  end

  always_comb begin
    gaddr  = bus.addr[gidx*ASIZE +: ASIZE];
    gwdata = bus.wdata[gidx*DSIZE +: DSIZE];
    gwr    = gnt_any & bus.wr[gidx];
    grd    = gnt_any & ~bus.wr[gidx];
    ptr_d  = ptr_q;
    if (gnt_any) ptr_d = (32'(gidx) == CH - 1) ? '0 : gidx + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        if (clr) begin
          cnt_d = '0;
        end else if (cnt_q == '1) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (state_q == CLEAR) mem[cnt_q] <= '0;
    else if (gwr)         mem[gaddr] <= gwdata;
  end

  // Data is captured at grant, so reads in flight across a clear keep old content;
  // each stage's data only moves with a valid, which makes the last stage hold rdata.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < RD_LAT; j++) begin
        vpipe[j] <= '0;
        dpipe[j] <= '0;
      end
    end else begin
      vpipe[0] <= grd ? gnt : '0;
      if (grd) dpipe[0] <= mem[gaddr];
      for (int unsigned j = 1; j < RD_LAT; j++) begin
        vpipe[j] <= vpipe[j-1];
        if (|vpipe[j-1]) dpipe[j] <= dpipe[j-1];
      end
    end
  end

  assign bus.gnt    = gnt;
  assign bus.rvalid = vpipe[RD_LAT-1];
  assign bus.rdata  = dpipe[RD_LAT-1];
  assign init_done  = (state_q == RUN);
endmodule
